// File: rtl/sprite_chain_tracker.sv
// Sprite parameter resolver: applies sticky-chain inheritance, computes the sprite line, and buffers results in a 2-entry FIFO.
// Optional statistics (SPR_COUNT, OVERRUN) are built only when SPR_TRACK_STATS_EN is defined.
module sprite_chain_tracker #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        NEW_LINE,
    input  logic        SPR_LOAD,
    input  logic [13:0] PIPE_C,
    input  logic [8:0]  SPR_Y,
    input  logic [5:0]  SPR_SIZE,
    input  logic [7:0]  YSHRINK,
    input  logic [8:0]  RASTERC,
    input  logic        FLIP,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [8:0]  OUT_X,
    output logic [3:0]  OUT_HSHRINK,
    output logic [4:0]  OUT_TILE_ROW,
    output logic [3:0]  OUT_PIX_ROW,
    output logic [7:0]  OUT_YSHRINK,
    output logic        OUT_IN_RANGE,
    output logic [6:0]  SPR_COUNT,
    output logic        OVERRUN
);

    localparam int CountW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [8:0] x;
        logic [3:0] hshrink;
        logic [4:0] tileRow;
        logic [3:0] pixRow;
        logic [7:0] yshrink;
        logic       inRange;
    } entry_t;

    logic [8:0] prevX_q, prevX_d;
    logic [4:0] prevW_q, prevW_d;
    logic [8:0] headY_q, headY_d;
    logic [5:0] headSize_q, headSize_d;
    logic [7:0] headYshrink_q, headYshrink_d;

    logic [8:0] ctxPrevX, ctxHeadY, resX, resY, line;
    logic [4:0] ctxPrevW;
    logic [5:0] ctxHeadSize, resSize;
    logic [7:0] ctxHeadYshrink, resYshrink;
    logic       chain;
    entry_t     s1Entry_d, s1Entry_q;
    logic       s1Valid_q;

    // NEW_LINE clears the context before a coincident load sees it
    always_comb begin
        chain          = PIPE_C[13];
        ctxPrevX       = NEW_LINE ? 9'd0 : prevX_q;
        ctxPrevW       = NEW_LINE ? 5'd0 : prevW_q;
        ctxHeadY       = NEW_LINE ? 9'd0 : headY_q;
        ctxHeadSize    = NEW_LINE ? 6'd0 : headSize_q;
        ctxHeadYshrink = NEW_LINE ? 8'hFF : headYshrink_q;

        resX       = chain ? (ctxPrevX + {4'd0, ctxPrevW}) : PIPE_C[8:0];
        resY       = chain ? ctxHeadY : SPR_Y;
        resSize    = chain ? ctxHeadSize : SPR_SIZE;
        resYshrink = chain ? ctxHeadYshrink : YSHRINK;
        line       = RASTERC + resY;

        s1Entry_d.x       = resX;
        s1Entry_d.hshrink = PIPE_C[12:9];
        s1Entry_d.tileRow = line[8:4];
        s1Entry_d.pixRow  = line[3:0] ^ {4{FLIP}};
        s1Entry_d.yshrink = resYshrink;
        s1Entry_d.inRange = (resSize >= 6'd32) || ({1'b0, line[8:4]} < resSize);

        prevX_d       = ctxPrevX;
        prevW_d       = ctxPrevW;
        headY_d       = ctxHeadY;
        headSize_d    = ctxHeadSize;
        headYshrink_d = ctxHeadYshrink;
        if (SPR_LOAD) begin
            prevX_d = resX;
            prevW_d = {1'b0, PIPE_C[12:9]} + 5'd1;
            if (!chain) begin
                headY_d       = SPR_Y;
                headSize_d    = SPR_SIZE;
                headYshrink_d = YSHRINK;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prevX_q       <= '0;
            prevW_q       <= '0;
            headY_q       <= '0;
            headSize_q    <= '0;
            headYshrink_q <= 8'hFF;
            s1Valid_q     <= 1'b0;
            s1Entry_q     <= '0;
        end else begin
            prevX_q       <= prevX_d;
            prevW_q       <= prevW_d;
            headY_q       <= headY_d;
            headSize_q    <= headSize_d;
            headYshrink_q <= headYshrink_d;
            s1Valid_q     <= SPR_LOAD;
            if (SPR_LOAD) begin
                s1Entry_q <= s1Entry_d;
            end
        end
    end

    entry_t              mem_q [2];
    logic                wrPtr_q, rdPtr_q;
    logic [CountW-1:0]   count_q;
    logic                pop, full, accept;
    entry_t              headEntry;

    always_comb begin
        pop    = (count_q != '0) && OUT_READY;
        full   = (count_q == CountW'(FIFO_DEPTH));
        accept = s1Valid_q && (!full || pop);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wrPtr_q  <= 1'b0;
            rdPtr_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                mem_q[wrPtr_q] <= s1Entry_q;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            if (accept && !pop) begin
                count_q <= count_q + CountW'(1);
            end else if (!accept && pop) begin
                count_q <= count_q - CountW'(1);
            end
        end
    end

    // An empty buffer presents the idle values rather than stale entries
    always_comb begin
        headEntry    = mem_q[rdPtr_q];
        OUT_VALID    = (count_q != '0);
        OUT_X        = OUT_VALID ? headEntry.x       : 9'd0;
        OUT_HSHRINK  = OUT_VALID ? headEntry.hshrink : 4'd0;
        OUT_TILE_ROW = OUT_VALID ? headEntry.tileRow : 5'd0;
        OUT_PIX_ROW  = OUT_VALID ? headEntry.pixRow  : 4'd0;
        OUT_YSHRINK  = OUT_VALID ? headEntry.yshrink : 8'hFF;
        OUT_IN_RANGE = OUT_VALID ? headEntry.inRange : 1'b0;
    end

`ifdef SPR_TRACK_STATS_EN
    logic [6:0] sprCount_q;
    logic       overrun_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sprCount_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (NEW_LINE) begin
                sprCount_q <= '0;
            end else if (accept && (sprCount_q < 7'd96)) begin
                sprCount_q <= sprCount_q + 7'd1;
            end
            if (s1Valid_q && !accept) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign SPR_COUNT = sprCount_q;
    assign OVERRUN   = overrun_q;
`else
    assign SPR_COUNT = 7'd0;
    assign OVERRUN   = 1'b0;
`endif

endmodule
